// File: rtl/ce_sync_tx_pkg.sv
// ----------------------------------------------------------------------------
// ce_sync_pkg
// Shared definitions for the clock-enable-qualified CDC source launcher:
//   - state_t        : launcher FSM states
//   - DEF_*          : default parameter values for ce_sync_tx
//   - XFER_COUNT_W   : width of the completed-transfer counter
// ----------------------------------------------------------------------------
package ce_sync_pkg;

   localparam int DEF_WIDTH        = 8;
   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_SETUP_CYCLES = 1;
   localparam int DEF_TIMEOUT      = 255;
   localparam int XFER_COUNT_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETUP    = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_ABORT    = 2'd3
   } state_t;

endpackage

// File: rtl/ce_sync_tx_bit_sync.sv
// ----------------------------------------------------------------------------
// bit_sync
// Plain STAGES-deep flop chain bringing one asynchronous bit into clk.
// No logic sits between stages so every stage has a full cycle to resolve.
// Ports:
//   clk    : destination clock for the synchronized bit
//   rst_n  : asynchronous active-low reset, chain clears to 0
//   i_d    : asynchronous input bit
//   o_q    : synchronized output (last stage)
// ----------------------------------------------------------------------------
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, giving a true shift chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ce_sync_tx.sv
// ----------------------------------------------------------------------------
// ce_sync_tx
// Source-side launcher of the clock-enable CDC path. Accepts a word over
// valid/ready, parks it on a stable bus, flips xfer_tgl after a settle window
// and waits for the destination's ack toggle (synchronized here) to match.
// Ports:
//   clk, rst_n   : source clock / asynchronous active-low reset
//   in_valid     : upstream word valid
//   in_ready     : high only in IDLE (and never while reset is asserted)
//   in_data      : upstream word
//   xfer_data    : payload held stable from accept to the next accept
//   xfer_tgl     : flips once per launched word
//   ack_tgl      : destination ack toggle, asynchronous to clk
//   busy         : high whenever the FSM is not in IDLE
//   timeout_err  : sticky abort flag, cleared only by reset
//   xfer_count   : number of acked transfers, wraps at 2^16
// ----------------------------------------------------------------------------
module ce_sync_tx
   import ce_sync_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   output logic [WIDTH-1:0]        xfer_data,
   output logic                    xfer_tgl,
   input  logic                    ack_tgl,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [XFER_COUNT_W-1:0] xfer_count
);

   // Counter widths leave room for the one harmless increment on exit.
   localparam int SET_W = (SETUP_CYCLES < 2) ? 1 : $clog2(SETUP_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [SET_W-1:0] SETUP_LAST = SET_W'(SETUP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [WIDTH-1:0]        r_xfer_data;
   logic                    r_xfer_tgl;
   logic [SET_W-1:0]        r_setup_cnt;
   logic [TO_W-1:0]         r_to_cnt;
   logic                    r_timeout_err;
   logic [XFER_COUNT_W-1:0] r_xfer_count;

   logic w_ack_s;
   logic w_accept;
   logic w_launch;
   logic w_done;
   logic w_abort;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (ack_tgl),
      .o_q   (w_ack_s)
   );

   // Next-state logic. Completion compares the synchronized ack against the
   // current toggle phase rather than looking for an ack edge, so a stale ack
   // left over from an aborted word can only match the old phase.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // leaves one unassigned would infer a latch.
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_launch    = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (r_setup_cnt == SETUP_LAST) begin
               w_launch    = 1'b1;
               w_state_nxt = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            // Ack is tested first so it wins a tie with the final timeout cycle.
            if (w_ack_s == r_xfer_tgl) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_to_cnt == TO_LAST) begin
               w_state_nxt = ST_ABORT;
            end
         end
         ST_ABORT: begin
            w_abort     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_xfer_data   <= '0;
         r_xfer_tgl    <= 1'b0;
         r_setup_cnt   <= '0;
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
         r_xfer_count  <= '0;
      end else begin
         r_state <= w_state_nxt;

         // The payload is only captured here, so it cannot move while a
         // toggle launched from it may still be crossing.
         if (w_accept) begin
            r_xfer_data <= in_data;
            r_setup_cnt <= '0;
         end else if (r_state == ST_SETUP) begin
            r_setup_cnt <= r_setup_cnt + SET_W'(1);
         end

         // The toggle is not reverted on abort; the destination stays in phase.
         if (w_launch) begin
            r_xfer_tgl <= ~r_xfer_tgl;
            r_to_cnt   <= '0;
         end else if (r_state == ST_WAIT_ACK) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end

         if (w_done) begin
            r_xfer_count <= r_xfer_count + XFER_COUNT_W'(1);
         end

         if (w_abort) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   // Gated by rst_n so upstream never sees ready while reset is held.
   assign in_ready    = rst_n & (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign xfer_data   = r_xfer_data;
   assign xfer_tgl    = r_xfer_tgl;
   assign timeout_err = r_timeout_err;
   assign xfer_count  = r_xfer_count;

endmodule

// File: tb/tb_ce_sync_tx.sv
// ----------------------------------------------------------------------------
// tb_ce_sync_tx
// Self-checking bench for ce_sync_tx. A small destination model drives
// ack_tgl either as a delayed copy of xfer_tgl or from a manual value.
// Expected values come from a transaction-level model: last accepted word,
// toggle phase = parity of launches, completed count, sticky error.
// ----------------------------------------------------------------------------
module tb_ce_sync_tx;

   localparam int WIDTH        = 8;
   localparam int SYNC_STAGES  = 2;
   localparam int SETUP_CYCLES = 1;
   localparam int TIMEOUT      = 8;
   localparam int MIN_PERIOD   = SETUP_CYCLES + SYNC_STAGES + 1;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic              in_valid = 1'b0;
   logic [WIDTH-1:0]  in_data  = '0;
   logic              ack_tgl  = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  xfer_data;
   logic              xfer_tgl;
   logic              busy;
   logic              timeout_err;
   logic [15:0]       xfer_count;

   ce_sync_tx #(
      .WIDTH        (WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .SETUP_CYCLES (SETUP_CYCLES),
      .TIMEOUT      (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .xfer_data   (xfer_data),
      .xfer_tgl    (xfer_tgl),
      .ack_tgl     (ack_tgl),
      .busy        (busy),
      .timeout_err (timeout_err),
      .xfer_count  (xfer_count)
   );

   always #5 clk = ~clk;

   // Destination model: ack follows xfer_tgl ack_delay cycles later, or a
   // manual level. Reset together with the DUT.
   bit         auto_ack  = 1'b0;
   bit         man_ack   = 1'b0;
   int         ack_delay = 0;
   logic [7:0] ack_hist  = '0;

   always @(negedge clk) begin
      if (!rst_n) ack_hist = '0;
      else        ack_hist = {ack_hist[6:0], xfer_tgl};
      ack_tgl = auto_ack ? ack_hist[ack_delay] : man_ack;
   end

   // Reference model state
   logic [WIDTH-1:0] exp_data  = '0;
   logic             exp_tgl   = 1'b0;
   logic [15:0]      exp_count = '0;
   logic             exp_err   = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      auto_ack = 1'b0;
      man_ack  = 1'b0;
      exp_data = '0; exp_tgl = 1'b0; exp_count = '0; exp_err = 1'b0;
      repeat (2) tick();
      #2 rst_n = 1'b1;
   endtask

   // Waits for ready (bounded), presents one word for exactly one edge.
   task automatic launch(input logic [WIDTH-1:0] d, output int t_acc);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL launch_ready: in_ready=%b after %0d cycles, want 1", in_ready, n);
      end
      in_data  = d;
      in_valid = 1'b1;
      tick();
      t_acc    = cyc;
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      exp_data = d;
      exp_tgl  = ~exp_tgl;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", tag, busy, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (xfer_data !== '0) begin n_bad++; $display("FAIL rst_xfer_data: got %h want 00", xfer_data); end
      n_cmp++; if (xfer_tgl !== 1'b0) begin n_bad++; $display("FAIL rst_xfer_tgl: got %b want 0", xfer_tgl); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", timeout_err); end
      n_cmp++; if (xfer_count !== 16'h0) begin n_bad++; $display("FAIL rst_count: got %h want 0000", xfer_count); end
      do_reset();
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_release_busy: got %b want 0", busy); end
   endtask

   task automatic test_single_word();
      int t;
      auto_ack  = 1'b1;
      ack_delay = 3;
      launch(8'hA5, t);
      n_cmp++; if (xfer_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", xfer_data); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_low: got %b want 0", in_ready); end
      n_cmp++; if (xfer_tgl !== ~exp_tgl) begin n_bad++; $display("FAIL single_tgl_pre: got %b want %b", xfer_tgl, ~exp_tgl); end
      repeat (SETUP_CYCLES) tick();
      n_cmp++; if (xfer_tgl !== exp_tgl) begin n_bad++; $display("FAIL single_tgl_flip: got %b want %b", xfer_tgl, exp_tgl); end
      wait_idle("single");
      exp_count++;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_back: got %b want 1", in_ready); end
      n_cmp++; if (xfer_count !== exp_count) begin n_bad++; $display("FAIL single_count: got %0d want %0d", xfer_count, exp_count); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", timeout_err); end
      n_cmp++; if (xfer_data !== 8'hA5) begin n_bad++; $display("FAIL single_data_hold: got %h want a5", xfer_data); end
   endtask

   task automatic test_back_to_back();
      int   acc_t[$];
      int   flips;
      int   idx;
      int   n;
      logic prev_tgl;
      logic rdy;
      logic vld;
      auto_ack  = 1'b1;
      ack_delay = 0;
      flips     = 0;
      idx       = 0;
      n         = 0;
      prev_tgl  = xfer_tgl;
      in_data   = 8'h01;
      in_valid  = 1'b1;
      while ((idx < 4 || busy) && n < 300) begin
         rdy = in_ready;
         vld = in_valid;
         tick();
         n++;
         if (xfer_tgl !== prev_tgl) flips++;
         prev_tgl = xfer_tgl;
         if (rdy && vld) begin
            acc_t.push_back(cyc);
            n_cmp++;
            if (xfer_data !== WIDTH'(idx + 1)) begin
               n_bad++;
               $display("FAIL b2b_data%0d: got %h want %h", idx, xfer_data, WIDTH'(idx + 1));
            end
            idx++;
            exp_tgl = ~exp_tgl;
            exp_count++;
            in_data = WIDTH'(idx + 1);
            if (idx == 4) in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      exp_data = 8'h04;
      n_cmp++; if (idx !== 4) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 4", idx); end
      for (int i = 1; i < acc_t.size(); i++) begin
         n_cmp++;
         if (acc_t[i] - acc_t[i-1] < MIN_PERIOD) begin
            n_bad++;
            $display("FAIL b2b_spacing%0d: got %0d cycles want >= %0d", i, acc_t[i] - acc_t[i-1], MIN_PERIOD);
         end
      end
      n_cmp++; if (flips !== 4) begin n_bad++; $display("FAIL b2b_flips: got %0d want 4", flips); end
      n_cmp++; if (xfer_tgl !== exp_tgl) begin n_bad++; $display("FAIL b2b_tgl: got %b want %b", xfer_tgl, exp_tgl); end
      n_cmp++; if (xfer_count !== exp_count) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", xfer_count, exp_count); end
   endtask

   task automatic test_data_stability();
      int t;
      int n;
      for (int k = 0; k < 6; k++) begin
         auto_ack  = 1'b1;
         ack_delay = $urandom_range(0, 3);
         launch(WIDTH'($urandom), t);
         n = 0;
         while (busy && n < 100) begin
            in_data  = WIDTH'($urandom);
            in_valid = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
            n++;
            n_cmp++;
            if (xfer_data !== exp_data) begin
               n_bad++;
               $display("FAIL stab%0d_data cyc %0d: got %h want %h", k, n, xfer_data, exp_data);
            end
         end
         in_valid = 1'b0;
         wait_idle("stab");
         exp_count++;
         n_cmp++; if (xfer_count !== exp_count) begin n_bad++; $display("FAIL stab%0d_count: got %0d want %0d", k, xfer_count, exp_count); end
         n_cmp++; if (xfer_tgl !== exp_tgl) begin n_bad++; $display("FAIL stab%0d_tgl: got %b want %b", k, xfer_tgl, exp_tgl); end
      end
   endtask

   task automatic test_reset_mid_transfer();
      int t;
      auto_ack  = 1'b1;
      ack_delay = 3;
      launch(WIDTH'($urandom), t);
      repeat (SETUP_CYCLES + 1) tick();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (xfer_data !== '0) begin n_bad++; $display("FAIL midrst_data: got %h want 00", xfer_data); end
      n_cmp++; if (xfer_tgl !== 1'b0) begin n_bad++; $display("FAIL midrst_tgl: got %b want 0", xfer_tgl); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
      n_cmp++; if (xfer_count !== 16'h0) begin n_bad++; $display("FAIL midrst_count: got %h want 0000", xfer_count); end
      do_reset();
      auto_ack  = 1'b1;
      ack_delay = 3;
      launch(8'h3C, t);
      n_cmp++; if (xfer_tgl !== 1'b0) begin n_bad++; $display("FAIL midrst_next_pre: got %b want 0", xfer_tgl); end
      repeat (SETUP_CYCLES) tick();
      n_cmp++; if (xfer_tgl !== 1'b1) begin n_bad++; $display("FAIL midrst_next_flip: got %b want 1", xfer_tgl); end
      wait_idle("midrst");
      exp_count++;
      n_cmp++; if (xfer_count !== exp_count) begin n_bad++; $display("FAIL midrst_next_count: got %0d want %0d", xfer_count, exp_count); end
      n_cmp++; if (xfer_data !== 8'h3C) begin n_bad++; $display("FAIL midrst_next_data: got %h want 3c", xfer_data); end
   endtask

   task automatic test_ack_timeout_tie();
      int t;
      do_reset();
      launch(WIDTH'($urandom), t);
      repeat (SETUP_CYCLES) tick();
      n_cmp++; if (xfer_tgl !== 1'b1) begin n_bad++; $display("FAIL tie_flip: got %b want 1", xfer_tgl); end
      // Timed so the synchronized ack reaches the FSM on the last timeout cycle.
      repeat (TIMEOUT - SYNC_STAGES - 1) tick();
      man_ack = exp_tgl;
      repeat (SYNC_STAGES) tick();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL tie_still_waiting: busy=%b want 1", busy); end
      tick();
      exp_count++;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tie_done_busy: got %b want 0", busy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL tie_ready: got %b want 1", in_ready); end
      n_cmp++; if (xfer_count !== exp_count) begin n_bad++; $display("FAIL tie_count: got %0d want %0d", xfer_count, exp_count); end
      tick();
      n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tie_err: got %b want 0", timeout_err); end
   endtask

   task automatic test_counter_wrap();
      int t;
      auto_ack  = 1'b1;
      ack_delay = 0;
      force dut.r_xfer_count = 16'hFFFF;
      #1;
      release dut.r_xfer_count;
      exp_count = 16'hFFFF;
      n_cmp++; if (xfer_count !== exp_count) begin n_bad++; $display("FAIL wrap_preload: got %h want %h", xfer_count, exp_count); end
      launch(WIDTH'($urandom), t);
      wait_idle("wrap");
      exp_count++;
      n_cmp++; if (xfer_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_count: got %h want 0000", xfer_count); end
   endtask

   task automatic test_timeout();
      int t;
      do_reset();
      launch(WIDTH'($urandom), t);
      repeat (SETUP_CYCLES) tick();
      n_cmp++; if (xfer_tgl !== 1'b1) begin n_bad++; $display("FAIL to_flip: got %b want 1", xfer_tgl); end
      repeat (TIMEOUT - 1) tick();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL to_wait_busy: got %b want 1", busy); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_early_err: got %b want 0", timeout_err); end
      tick();
      n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL to_abort_state: busy=%b ready=%b want 1/0", busy, in_ready); end
      tick();
      exp_err = 1'b1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready: got %b want 1", in_ready); end
      n_cmp++; if (timeout_err !== exp_err) begin n_bad++; $display("FAIL to_err: got %b want %b", timeout_err, exp_err); end
      n_cmp++; if (xfer_count !== exp_count) begin n_bad++; $display("FAIL to_count: got %0d want %0d", xfer_count, exp_count); end
      n_cmp++; if (xfer_tgl !== exp_tgl) begin n_bad++; $display("FAIL to_tgl_kept: got %b want %b", xfer_tgl, exp_tgl); end
      // Late ack of the aborted word must not complete the next launch.
      man_ack = 1'b1;
      repeat (4) tick();
      n_cmp++; if (xfer_count !== exp_count || busy !== 1'b0) begin n_bad++; $display("FAIL to_stale_idle: count=%0d busy=%b want %0d/0", xfer_count, busy, exp_count); end
      launch(WIDTH'($urandom), t);
      repeat (SETUP_CYCLES) tick();
      n_cmp++; if (xfer_tgl !== exp_tgl) begin n_bad++; $display("FAIL to_next_flip: got %b want %b", xfer_tgl, exp_tgl); end
      repeat (3) tick();
      n_cmp++; if (busy !== 1'b1 || xfer_count !== exp_count) begin n_bad++; $display("FAIL to_stale_ack: busy=%b count=%0d want 1/%0d", busy, xfer_count, exp_count); end
      man_ack = exp_tgl;
      wait_idle("to_next");
      exp_count++;
      n_cmp++; if (xfer_count !== exp_count) begin n_bad++; $display("FAIL to_next_count: got %0d want %0d", xfer_count, exp_count); end
      n_cmp++; if (timeout_err !== exp_err) begin n_bad++; $display("FAIL to_err_sticky: got %b want %b", timeout_err, exp_err); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_data_stability();
      test_reset_mid_transfer();
      test_ack_timeout_tie();
      test_counter_wrap();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ce_sync_tx.md
# ce_sync_tx

Source-side launcher for the clock-enable-qualified CDC path. It accepts a word through a valid/ready handshake and holds it on a stable bus. After a settle window it flips a toggle that the destination uses to derive its clock enable. It then waits for the destination's ack toggle, synchronized internally, before accepting the next word. It sits in the source clock domain, directly in front of the destination-side enable synchronizer.

## Interface
- WIDTH, 8, payload width in bits.
- SYNC_STAGES, 2, flops in the ack_tgl synchronizer (legal values ≥2).
- SETUP_CYCLES, 1, cycles xfer_data is held stable before xfer_tgl flips (legal values ≥1).
- TIMEOUT, 255, maximum WAIT_ACK cycles before abort (legal values ≥1; counter width clog2(TIMEOUT+1)).

Ports:
- clk  in  1  source clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  WIDTH  upstream word.
- xfer_data  out  WIDTH  registered payload, stable from launch until the next accept.
- xfer_tgl  out  1  registered toggle; each flip marks one new word.
- ack_tgl  in  1  destination ack toggle; asynchronous to clk.
- busy  out  1  high when not in IDLE.
- timeout_err  out  1  sticky; set on abort; cleared only by reset.
- xfer_count  out  16  completed (acked) transfers; wraps at 2^16.

## Operation
- The shared package defines four states: IDLE, SETUP, WAIT_ACK, ABORT.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready: xfer_data<=in_data, settle counter<=0, go to SETUP.
- SETUP:
  - The counter increments each cycle.
  - When the counter reaches SETUP_CYCLES-1: xfer_tgl<=~xfer_tgl, timeout counter<=0, go to WAIT_ACK.
- WAIT_ACK:
  - ack_s is the synchronized ack_tgl.
  - If ack_s==xfer_tgl: xfer_count++ and go to IDLE.
  - Otherwise, if the timeout counter equals TIMEOUT-1: go to ABORT.
  - Otherwise: timeout counter++.
- ABORT:
  - Set timeout_err=1.
  - Go to IDLE the next cycle. xfer_tgl is not reverted.
- Completion compares against xfer_tgl, not an ack edge. A stale ack arriving after an abort therefore matches the old phase only and cannot complete a later transfer early.
- in_valid outside IDLE is ignored. in_data is not sampled.
- xfer_data changes only on accept in IDLE. It never changes while xfer_tgl may still be in flight.

## Timing
- Reset values:
  - in_ready=0 while rst_n is low, 1 after release.
  - xfer_data=0, xfer_tgl=0, busy=0, timeout_err=0, xfer_count=0.
  - Ack sync flops=0, state=IDLE.
- Accept at edge T:
  - xfer_data is valid after T.
  - xfer_tgl flips at edge T+SETUP_CYCLES.
  - in_ready=0 from T until completion.
- Ack latency: an ack_tgl change is visible to the FSM SYNC_STAGES edges after it is stably sampled. Completion occurs on that edge. in_ready=1 in the following cycle.
- Minimum accept-to-accept period: SETUP_CYCLES + SYNC_STAGES + 1 cycles, given an immediate ack.
- Abort: the ABORT state is entered TIMEOUT cycles after the toggle flip. in_ready=1 one cycle later.
- If an ack match and a timeout occur on the same cycle, the ack wins: the transfer completes with no error.
- xfer_count wraps from 0xFFFF to 0x0000.
- Asserting rst_n mid-transfer:
  - Immediately returns every register to its reset value, including xfer_tgl=0.
  - The destination must be reset together with this block.

## Structure
- Package ce_sync_pkg holds:
  - The state enum type.
  - The default parameter constants.
  - The xfer_count width constant (16).
- Sub-module bit_sync is the SYNC_STAGES-deep single-bit flop chain for ack_tgl:
  - Asynchronous active-low reset to 0.
  - No logic between its stages.
- The top level holds the FSM, the settle and timeout counters, and the output registers.

## Test plan
- Reset then single word:
  - Stimulus: in_data=0xA5, in_valid for 1 cycle; ack_tgl tied to xfer_tgl with a 3-cycle delay.
  - Required: xfer_data=0xA5 after accept, xfer_tgl=1 at T+1, in_ready returns, xfer_count=1, timeout_err=0.
- Back-to-back:
  - Stimulus: 4 words 0x01..0x04 with in_valid held high and an immediate ack loop.
  - Required: each word is accepted only in IDLE, accept spacing is ≥ SETUP_CYCLES+SYNC_STAGES+1, xfer_tgl flips 4 times, xfer_count=4.
- Timeout:
  - Stimulus: ack_tgl held at 0, TIMEOUT=8, one word launched.
  - Required: ABORT is entered 8 cycles after the flip, timeout_err=1 (sticky), xfer_count=0, in_ready=1.
  - Follow-up: a later ack_tgl=1 does not complete the next launch (xfer_tgl=0 after its flip) until ack_tgl=0.
- Data stability:
  - Stimulus: in_data changes every cycle during SETUP and WAIT_ACK.
  - Required: xfer_data is constant between accepts.
- Reset mid-transfer:
  - Stimulus: rst_n low during WAIT_ACK.
  - Required: all outputs are at reset values in the same cycle, and the next transfer starts cleanly with xfer_tgl flipping 0→1.
- Counter wrap and ack/timeout tie:
  - Stimulus 1: preload xfer_count to 0xFFFF, then one completion.
  - Required: xfer_count=0x0000.
  - Stimulus 2: ack match arriving on the final timeout cycle.
  - Required: completion, timeout_err=0.
